// File: rtl/relu_conv_2d_div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package relu_conv_2d_div_pkg;

  localparam int unsigned DIN0_W = 21;
  localparam int unsigned DIN1_W = 12;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Quotient reported when the captured divisor is zero.
  localparam logic [DIN0_W-1:0] DBZ_QUOT = '1;

endpackage

// File: rtl/relu_conv_2d_udiv_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// conditionally subtract the divisor, emit the quotient bit.
module relu_conv_2d_udiv_step #(
  parameter int unsigned DIV_W = 12
) (
  input  logic [DIV_W:0]   part_i,
  input  logic             bit_i,
  input  logic [DIV_W-1:0] div_i,
  output logic [DIV_W:0]   part_o,
  output logic             qbit_o
);

  logic [DIV_W:0] shifted_c;
  logic [DIV_W:0] diff_c;
  logic           ge_c;

  // A set carry-out bit means the shifted partial already exceeds any divisor.
  always_comb begin
    shifted_c = {part_i[DIV_W-1:0], bit_i};
    diff_c    = shifted_c - {1'b0, div_i};
    ge_c      = part_i[DIV_W] | (shifted_c >= {1'b0, div_i});
    part_o    = ge_c ? diff_c : shifted_c;
    qbit_o    = ge_c;
  end

endmodule

// File: rtl/relu_conv_2d_udiv_21ns_12ns_seq.sv
// Sequential unsigned restoring divider with valid/ready on both sides;
// one quotient bit per cycle, quotient shifted in over the dividend.
module relu_conv_2d_udiv_21ns_12ns_seq
  import relu_conv_2d_div_pkg::*;
#(
  parameter int unsigned din0_WIDTH = DIN0_W,
  parameter int unsigned din1_WIDTH = DIN1_W,
  parameter int unsigned CNT_WIDTH  = CNT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [din0_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  div_state_t            state_q, state_d;
  logic [din0_WIDTH-1:0] quot_q, quot_d;
  logic [din1_WIDTH-1:0] div_q, div_d;
  logic [din1_WIDTH:0]   part_q, part_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  dbz_q, dbz_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  logic [din1_WIDTH:0]   step_part_c;
  logic                  step_qbit_c;

  relu_conv_2d_udiv_step #(
    .DIV_W (din1_WIDTH)
  ) u_step (
    .part_i (part_q),
    .bit_i  (quot_q[din0_WIDTH-1]),
    .div_i  (div_q),
    .part_o (step_part_c),
    .qbit_o (step_qbit_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    quot_d      = quot_q;
    div_d       = div_q;
    part_d      = part_q;
    cnt_d       = cnt_q;
    dbz_d       = dbz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          quot_d     = din0;
          div_d      = din1;
          part_d     = '0;
          cnt_d      = CNT_WIDTH'(din0_WIDTH - 1);
          dbz_d      = (din1 == '0);
          in_ready_d = 1'b0;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        quot_d = {quot_q[din0_WIDTH-2:0], step_qbit_c};
        part_d = step_part_c;
        if (cnt_q == '0) begin
          // Zero divisor already yields all-ones/low dividend bits; force the quotient anyway.
          if (dbz_q) quot_d = din0_WIDTH'(DBZ_QUOT);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      quot_q      <= '0;
      div_q       <= '0;
      part_q      <= '0;
      cnt_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      quot_q      <= quot_d;
      div_q       <= div_d;
      part_q      <= part_d;
      cnt_q       <= cnt_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quot        = quot_q;
  assign rem         = part_q[din1_WIDTH-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_relu_conv_2d_udiv_21ns_12ns_seq.sv
// Self-checking bench for the 21/12 sequential divider: directed vectors,
// random operands against an arithmetic model, backpressure and reset abort.
module tb_relu_conv_2d_udiv_21ns_12ns_seq;

  localparam int unsigned W0 = 21;
  localparam int unsigned W1 = 12;
  localparam int unsigned LAT = 21;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W0-1:0] din0;
  logic [W1-1:0] din1;
  logic          out_valid;
  logic          out_ready;
  logic [W0-1:0] quot;
  logic [W1-1:0] rem;
  logic          div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    logic [W0-1:0] q;
    logic [W1-1:0] r;
    logic          z;
  } vec_t;

  vec_t vecs [4];

  relu_conv_2d_udiv_21ns_12ns_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din0        (din0),
    .din1        (din1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer division with the zero-divisor rule.
  task automatic model(input logic [W0-1:0] a, input logic [W1-1:0] b,
                       output logic [W0-1:0] q, output logic [W1-1:0] r, output logic z);
    if (b == 0) begin
      q = {W0{1'b1}};
      r = a[W1-1:0];
      z = 1'b1;
    end else begin
      q = W0'(int'(a) / int'(b));
      r = W1'(int'(a) % int'(b));
      z = 1'b0;
    end
  endtask

  // Accept a pair, scramble inputs afterwards, wait for the result (bounded).
  task automatic start_op(input logic [W0-1:0] a, input logic [W1-1:0] b);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    din0 = a;
    din1 = b;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    din0 = W0'($urandom);
    din1 = W1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge ap_clk);
      #1;
      lat++;
    end
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W0-1:0] a, input logic [W1-1:0] b);
    logic [W0-1:0] eq;
    logic [W1-1:0] er;
    logic          ez;
    int            lat;
    model(a, b, eq, er, ez);
    start_op(a, b);
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    wait_result(lat);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_quot"}, 32'(quot), 32'(eq));
    check({tag, "_rem"}, 32'(rem), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W0-1:0] hold_q;
    logic [W1-1:0] hold_r;
    int            lat;

    vecs[0] = '{a: 21'd1000000, b: 12'd1000, q: 21'd1000,    r: 12'd0,   z: 1'b0};
    vecs[1] = '{a: 21'd2097151, b: 12'd4095, q: 21'd512,     r: 12'd511, z: 1'b0};
    vecs[2] = '{a: 21'd7,       b: 12'd100,  q: 21'd0,       r: 12'd7,   z: 1'b0};
    vecs[3] = '{a: 21'd12345,   b: 12'd0,    q: 21'd2097151, r: 12'd57,  z: 1'b1};

    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = '0;
    din1      = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quot", 32'(quot), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // Directed vectors with hand-computed results.
    for (int i = 0; i < 4; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result(lat);
      check("vec_latency", 32'(lat), 32'(LAT));
      check("vec_quot", 32'(quot), 32'(vecs[i].q));
      check("vec_rem", 32'(rem), 32'(vecs[i].r));
      check("vec_dbz", 32'(div_by_zero), 32'(vecs[i].z));
      out_ready = 1'b1;
      @(posedge ap_clk);
      #1;
      out_ready = 1'b0;
      check("vec_in_ready_after", 32'(in_ready), 32'd1);
    end

    // Random operands, with some zero and tiny divisors mixed in.
    for (int i = 0; i < 24; i++) begin
      logic [W0-1:0] a;
      logic [W1-1:0] b;
      a = W0'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W1'($urandom_range(1, 3));
        default: b = W1'($urandom);
      endcase
      run_op("rand", a, b);
    end

    // Backpressure: result held, new request ignored, drain on out_ready.
    start_op(21'd100000, 12'd333);
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'(LAT));
    hold_q = quot;
    hold_r = rem;
    check("bp_quot", 32'(hold_q), 32'd300);
    check("bp_rem", 32'(hold_r), 32'd100);
    in_valid = 1'b1;
    din0 = 21'd55;
    din1 = 12'd5;
    for (int c = 0; c < 5; c++) begin
      @(posedge ap_clk);
      #1;
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_quot_held", 32'(quot), 32'(hold_q));
      check("bp_rem_held", 32'(rem), 32'(hold_r));
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    repeat (3) @(posedge ap_clk);
    #1;
    check("bp_no_phantom_op", 32'(in_ready), 32'd1);

    // Reset asserted mid-calculation aborts at once.
    start_op(21'd1999999, 12'd37);
    repeat (10) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_quot", 32'(quot), 32'd0);
    check("abort_rem", 32'(rem), 32'd0);
    repeat (10) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    run_op("post_rst", 21'd100, 12'd7);
    check("post_rst_expect_q", 32'(int'(100) / 7), 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
